// File: rtl/n3_deser_pkg.sv
// rtl/n3_deser_pkg.sv - shared types, defaults and helpers for the n3 deserializer
// Contents: output FSM state enum, default WIDTH/CNT_W, bit_idx width helper.
package n3_deser_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_t;

    function automatic int bit_idx_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/n3_shift_collector.sv
// rtl/n3_shift_collector.sv - LSB-first serial-to-parallel collector for the n3 bit stream
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   n3, in_en        serial bit and its qualifier
//   flush            drops the partial word (wins over in_en)
//   bit_idx          bits collected so far in the current word
//   done             one-cycle pulse, combinational, on the edge that completes a word
//   word             completed word, valid while done=1
module n3_shift_collector
    import n3_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int IDX_W = bit_idx_width(DEF_WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             n3,
    input  logic             in_en,
    input  logic             flush,
    output logic [IDX_W-1:0] bit_idx,
    output logic             done,
    output logic [WIDTH-1:0] word
);

    logic [WIDTH-1:0] sr;
    logic             last;

    assign last = (bit_idx == IDX_W'(WIDTH - 1));
    // The word is formed from the incoming bit directly so the top can
    // register it on the same edge that shifts the final bit in.
    assign word = {n3, sr[WIDTH-1:1]};
    assign done = in_en & ~flush & last;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr      <= '0;
            bit_idx <= '0;
        end else if (flush) begin
            sr      <= '0;
            bit_idx <= '0;
        end else if (in_en) begin
            sr      <= word;
            bit_idx <= last ? '0 : bit_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/n3_deserializer.sv
// rtl/n3_deserializer.sv - collects the n3 stream into WIDTH-bit words on a valid/ready output
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   n3, in_en, flush      serial input, qualifier, partial-word discard
//   clr_ovf               clears the sticky overflow flag
//   out_data/out_valid/out_ready   word output handshake
//   bit_idx               bits in the current partial word
//   word_count            accepted words, wraps
//   overflow              sticky: a completed word was dropped
module n3_deserializer
    import n3_deser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              n3,
    input  logic                              in_en,
    input  logic                              flush,
    input  logic                              clr_ovf,
    output logic [WIDTH-1:0]                  out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [bit_idx_width(WIDTH)-1:0]   bit_idx,
    output logic [CNT_W-1:0]                  word_count,
    output logic                              overflow
);

    localparam int IDX_W = bit_idx_width(WIDTH);

    out_state_t       state, next_state;
    logic             done;
    logic [WIDTH-1:0] word;
    logic             load;
    logic             drop;

    n3_shift_collector #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_collector (
        .clk     (clk),
        .reset   (reset),
        .n3      (n3),
        .in_en   (in_en),
        .flush   (flush),
        .bit_idx (bit_idx),
        .done    (done),
        .word    (word)
    );

    assign out_valid = (state == FULL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // A completion while FULL either replaces the word being consumed this
    // edge or, if the consumer is stalled, is discarded and flagged.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        drop       = 1'b0;
        case (state)
            EMPTY: begin
                if (done) begin
                    next_state = FULL;
                    load       = 1'b1;
                end
            end
            FULL: begin
                if (done) begin
                    if (out_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_ready) begin
                    next_state = EMPTY;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
        end else if (load) begin
            out_data <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count <= '0;
        end else if (out_valid && out_ready) begin
            word_count <= word_count + CNT_W'(1);
        end
    end

    // A drop on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_n3_deserializer.sv
// tb/tb_n3_deserializer.sv - scoreboard bench for n3_deserializer (WIDTH=8, CNT_W=16)
module tb_n3_deserializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        n3;
    logic        in_en;
    logic        flush;
    logic        clr_ovf;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  bit_idx;
    logic [15:0] word_count;
    logic        overflow;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    n3_deserializer #(.WIDTH(8), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .n3         (n3),
        .in_en      (in_en),
        .flush      (flush),
        .clr_ovf    (clr_ovf),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .bit_idx    (bit_idx),
        .word_count (word_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a handshake is what the DUT sees at the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
                end else begin
                    check("handshake_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        n3    = b;
        in_en = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                if (rdy_last) out_ready = 1'b1;
                clr_ovf = clr_last;
            end
            send_bit(w[i]);
        end
        in_en   = 1'b0;
        clr_ovf = 1'b0;
    endtask

    task automatic handshake(input logic [7:0] w);
        exp_q.push_back(w);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] w;
        reset = 1'b1; n3 = 1'b0; in_en = 1'b0; flush = 1'b0;
        clr_ovf = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_data", {24'd0, out_data}, 0);
        check("rst_bit_idx", {29'd0, bit_idx}, 0);
        check("rst_word_count", {16'd0, word_count}, 0);
        check("rst_overflow", {31'd0, overflow}, 0);

        // first word 1,0,1,1,0,0,0,1 -> 0x8D, valid one cycle after 8th edge
        w = 8'h8D;
        for (int i = 0; i < 7; i++) send_bit(w[i]);
        check("t1_not_valid_early", {31'd0, out_valid}, 0);
        check("t1_bit_idx7", {29'd0, bit_idx}, 7);
        send_bit(w[7]);
        in_en = 1'b0;
        check("t1_valid", {31'd0, out_valid}, 1);
        check("t1_data", {24'd0, out_data}, 32'h8D);
        check("t1_bit_idx", {29'd0, bit_idx}, 0);
        handshake(8'h8D);
        check("t1_wc", {16'd0, word_count}, 1);
        check("t1_valid_drop", {31'd0, out_valid}, 0);

        // back-to-back with out_ready held high
        out_ready = 1'b1;
        exp_q.push_back(8'h8D); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
        send_word(8'h8D, 1'b0, 1'b0);
        in_en = 1'b1;
        send_word(8'hFF, 1'b0, 1'b0);
        in_en = 1'b1;
        send_word(8'h00, 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        check("t2_wc", {16'd0, word_count}, 4);
        check("t2_overflow", {31'd0, overflow}, 0);
        check("t2_q_empty", exp_q.size(), 0);

        // stalled consumer: second word dropped
        send_word(8'h8D, 1'b0, 1'b0);
        send_word(8'h55, 1'b0, 1'b0);
        check("t3_overflow", {31'd0, overflow}, 1);
        check("t3_data_held", {24'd0, out_data}, 32'h8D);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t3_ovf_cleared", {31'd0, overflow}, 0);
        check("t3_data_after_clr", {24'd0, out_data}, 32'h8D);
        send_word(8'h0F, 1'b0, 1'b1);
        check("t3_drop_beats_clr", {31'd0, overflow}, 1);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("t3_ovf_cleared2", {31'd0, overflow}, 0);
        handshake(8'h8D);
        check("t3_wc", {16'd0, word_count}, 5);

        // flush discards partial word and the bit on its own edge
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        check("t4_bit_idx5", {29'd0, bit_idx}, 5);
        flush = 1'b1; n3 = 1'b1; in_en = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_en = 1'b0;
        check("t4_bit_idx_flush", {29'd0, bit_idx}, 0);
        check("t4_no_valid", {31'd0, out_valid}, 0);
        send_word(8'hA5, 1'b0, 1'b0);
        check("t4_data", {24'd0, out_data}, 32'hA5);
        handshake(8'hA5);
        check("t4_wc", {16'd0, word_count}, 6);

        // completion and handshake on the same edge
        send_word(8'h11, 1'b0, 1'b0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_word(8'h22, 1'b1, 1'b0);
        check("t5_data", {24'd0, out_data}, 32'h22);
        check("t5_valid", {31'd0, out_valid}, 1);
        check("t5_overflow", {31'd0, overflow}, 0);
        check("t5_wc", {16'd0, word_count}, 7);
        @(negedge clk);
        out_ready = 1'b0;
        check("t5_wc2", {16'd0, word_count}, 8);

        // reset mid-word with a pending word and overflow set
        send_word(8'h77, 1'b0, 1'b0);
        send_word(8'h66, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        in_en = 1'b0;
        check("t6_pre_bit_idx", {29'd0, bit_idx}, 4);
        check("t6_pre_valid", {31'd0, out_valid}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_valid", {31'd0, out_valid}, 0);
        check("t6_data", {24'd0, out_data}, 0);
        check("t6_bit_idx", {29'd0, bit_idx}, 0);
        check("t6_wc", {16'd0, word_count}, 0);
        check("t6_overflow", {31'd0, overflow}, 0);
        send_word(8'h3C, 1'b0, 1'b0);
        check("t6_data_after", {24'd0, out_data}, 32'h3C);
        handshake(8'h3C);
        check("t6_wc_after", {16'd0, word_count}, 1);

        // word_count wrap
        send_word(8'h5A, 1'b0, 1'b0);
        exp_q.push_back(8'h5A);
        out_ready = 1'b1;
        force dut.word_count = 16'hFFFF;
        #2;
        release dut.word_count;
        @(negedge clk);
        out_ready = 1'b0;
        check("t7_wc_wrap", {16'd0, word_count}, 0);
        check("t7_valid", {31'd0, out_valid}, 0);

        repeat (2) @(negedge clk);
        check("final_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
